mult_share_arbiter: RTL and testbench

Round-robin scheduler that shares one sequential 8x8 multiplier among NREQ requesters. It accepts operand pairs and issues the single-cycle start pulse with held operands. It waits for the multiplier's done flag, with a watchdog timeout, and returns the 16-bit product to the requester that issued the operands. The block sits between the requester blocks and the multiplier's start/dataa/datab/done_flag/product8x8_out pins.

---
 rtl/mult_share_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mult_share_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin scheduler sharing one sequential 8x8 multiplier among NREQ requesters.
// Issues a start pulse with held operands, waits for done (with watchdog) and returns the product.
module mult_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_a,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_dataa,
    input  logic [8*NREQ-1:0] req_datab,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [15:0]       rsp_product,
    output logic              rsp_error,
    output logic              busy,
    output logic              mult_start,
    output logic [7:0]        mult_dataa,
    output logic [7:0]        mult_datab,
    input  logic              mult_done,
    input  logic [15:0]       mult_product,
    output logic [1:0]        dbg_state
);
    // Handshake: a request is committed on the IDLE clock edge that sees req_valid[i]=1;
    // req_ready[i] pulses one cycle later as an acknowledgement, and dropping req_valid
    // after commit does not cancel the operation. rsp_valid[i] is a one-cycle pulse
    // qualifying rsp_product and rsp_error.
    localparam int              IW       = $clog2(NREQ);
    localparam logic [IW:0]     NREQ_W   = (IW+1)'(NREQ);
    localparam logic [7:0]      CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [IW-1:0]   LAST_RST = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LAUNCH  = 2'd1,
        S_WAIT    = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q, last_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            armed_q, armed_d;
    logic [NREQ-1:0] ready_q, ready_d;
    logic [NREQ-1:0] rspv_q, rspv_d;
    logic [15:0]     prod_q, prod_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic            start_q, start_d;
    logic [7:0]      a_q, a_d;
    logic [7:0]      b_q, b_d;

    logic            grant_found;
    logic [IW-1:0]   grant_idx;
    logic [IW:0]     cand;
    logic [NREQ-1:0] grant_oh;
    logic [NREQ-1:0] owner_oh;
    logic [7:0]      sel_a, sel_b;

    // Search starts one past the last served requester and wraps at NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = {1'b0, last_q} + (IW+1)'(i);
            if (cand >= NREQ_W) cand = cand - NREQ_W;
            if (!grant_found && req_valid[cand[IW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (grant_idx == IW'(j)) begin
                sel_a = req_dataa[8*j +: 8];
                sel_b = req_datab[8*j +: 8];
            end
        end
    end

    always_comb begin
        grant_oh            = '0;
        grant_oh[grant_idx] = 1'b1;
        owner_oh            = '0;
        owner_oh[owner_q]   = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        a_d     = a_q;
        b_d     = b_q;
        ready_d = '0;
        rspv_d  = '0;
        prod_d  = '0;
        err_d   = 1'b0;
        start_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    state_d = S_LAUNCH;
                    owner_d = grant_idx;
                    a_d     = sel_a;
                    b_d     = sel_b;
                    ready_d = grant_oh;
                    start_d = 1'b1;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
                cnt_d   = '0;
                armed_d = 1'b0;
            end
            S_WAIT: begin
                // Done only counts after a low sample, so a flag left high by the previous job is ignored.
                if (armed_q && mult_done) begin
                    state_d = S_RESPOND;
                    rspv_d  = owner_oh;
                    prod_d  = mult_product;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_RESPOND;
                    rspv_d  = owner_oh;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (!mult_done) armed_d = 1'b1;
                end
            end
            S_RESPOND: begin
                state_d = S_IDLE;
                last_d  = owner_q;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
            armed_q <= 1'b0;
            ready_q <= '0;
            rspv_q  <= '0;
            prod_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            ready_q <= ready_d;
            rspv_q  <= rspv_d;
            prod_q  <= prod_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign req_ready   = ready_q;
    assign rsp_valid   = rspv_q;
    assign rsp_product = prod_q;
    assign rsp_error   = err_q;
    assign busy        = busy_q;
    assign mult_start  = start_q;
    assign mult_dataa  = a_q;
    assign mult_datab  = b_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: vector table of single operations plus
// hand-written sequences for round-robin, stale done, timeout and mid-operation reset.
module tb_mult_share_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 15;
    localparam int W       = NREQ + 1 + 16;

    logic              clk = 1'b0;
    logic              reset_a = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_dataa = '0;
    logic [8*NREQ-1:0] req_datab = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [15:0]       rsp_product;
    logic              rsp_error;
    logic              busy;
    logic              mult_start;
    logic [7:0]        mult_dataa;
    logic [7:0]        mult_datab;
    logic              mult_done = 1'b0;
    logic [15:0]       mult_product = '0;
    logic [1:0]        dbg_state;

    mult_share_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset_a      (reset_a),
        .req_valid    (req_valid),
        .req_dataa    (req_dataa),
        .req_datab    (req_datab),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_product  (rsp_product),
        .rsp_error    (rsp_error),
        .busy         (busy),
        .mult_start   (mult_start),
        .mult_dataa   (mult_dataa),
        .mult_datab   (mult_datab),
        .mult_done    (mult_done),
        .mult_product (mult_product),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int rsp_seen = 0;
    logic [W-1:0] exp_q[$];
    int grant_log[$];
    logic [7:0] op_a[NREQ];
    logic [7:0] op_b[NREQ];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // ---------------- multiplier model ----------------
    // Done stays high after completion until the next start (stale-done source).
    int   m_lat = 4, m_cur_lat = 4, m_age = 0;
    bit   m_stale = 1'b0, m_cur_stale = 1'b0, m_active = 1'b0;
    logic [15:0] m_pend = '0;

    always @(negedge clk) begin
        if (mult_start) begin
            m_pend      = 16'(mult_dataa) * 16'(mult_datab);
            m_age       = 0;
            m_active    = 1'b1;
            m_cur_lat   = m_lat;
            m_cur_stale = m_stale;
            if (!m_stale) mult_done = 1'b0;
        end else if (m_active) begin
            m_age++;
            if (m_cur_stale) begin
                if (m_age == 2) mult_done = 1'b0;
                if (m_age == 5) begin
                    mult_done    = 1'b1;
                    mult_product = m_pend;
                end
            end else if (m_cur_lat != 0 && m_age == m_cur_lat) begin
                mult_done    = 1'b1;
                mult_product = m_pend;
            end
        end
    end

    // ---------------- scoreboard ----------------
    always @(posedge clk) begin
        #1;
        if (rsp_valid !== '0) begin
            rsp_seen++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rsp_valid=0x%0h expected none at %0t", rsp_valid, $time);
            end else begin
                chk("rsp{valid,error,product}", {11'd0, rsp_valid, rsp_error, rsp_product}, {11'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic drive_req(input int idx, input logic [7:0] a, input logic [7:0] b);
        req_valid[idx]        = 1'b1;
        req_dataa[8*idx +: 8] = a;
        req_datab[8*idx +: 8] = b;
    endtask

    task automatic do_op(input int idx, input logic [7:0] a, input logic [7:0] b, input int lat,
                         input bit stale, input logic [15:0] exp_p, input logic exp_e, input int exp_cyc);
        int n;
        int target;
        wait_idle();
        m_lat   = lat;
        m_stale = stale;
        exp_q.push_back({oh(idx), exp_e, exp_p});
        target = rsp_seen + 1;
        drive_req(idx, a, b);
        @(negedge clk);
        n = 1;
        chk("launch_ready", {28'd0, req_ready}, {28'd0, oh(idx)});
        chk("launch_start", {31'd0, mult_start}, 32'd1);
        chk("launch_dataa", {24'd0, mult_dataa}, {24'd0, a});
        chk("launch_datab", {24'd0, mult_datab}, {24'd0, b});
        chk("launch_busy", {31'd0, busy}, 32'd1);
        chk("launch_state", {30'd0, dbg_state}, 32'd1);
        req_valid[idx] = 1'b0;
        @(negedge clk);
        n = 2;
        chk("wait_start_low", {31'd0, mult_start}, 32'd0);
        chk("wait_ready_low", {28'd0, req_ready}, 32'd0);
        chk("wait_dataa_held", {24'd0, mult_dataa}, {24'd0, a});
        while (rsp_seen < target && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_cycle", n, exp_cyc);
        @(negedge clk);
        chk("rsp_pulse_end", {28'd0, rsp_valid}, 32'd0);
        chk("busy_fall", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_burst(input logic [NREQ-1:0] mask, input int n_rsp, input int budget,
                             output int n_end, output int first_rdy);
        int target;
        int n;
        target    = rsp_seen + n_rsp;
        n         = 0;
        first_rdy = -1;
        grant_log.delete();
        for (int i = 0; i < NREQ; i++)
            if (mask[i]) drive_req(i, op_a[i], op_b[i]);
        while (rsp_seen < target && n < budget) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) begin
                    grant_log.push_back(i);
                    req_valid[i] = 1'b0;
                    if (first_rdy < 0) first_rdy = n;
                end
            end
        end
        n_end = n;
    endtask

    task automatic chk_order(input string nm, input int exp0, input int exp1, input int exp2,
                             input int exp3, input int cnt);
        int e[4];
        e = '{exp0, exp1, exp2, exp3};
        chk({nm, "_count"}, grant_log.size(), cnt);
        for (int i = 0; i < cnt; i++)
            chk(nm, (i < grant_log.size()) ? grant_log[i] : 99, e[i]);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        int          idx;
        logic [7:0]  a;
        logic [7:0]  b;
        int          lat;
        logic [15:0] prod;
        logic        err;
        int          rcyc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int n_end, first_rdy, n, target, n1, n2;

        vecs[0] = '{0, 8'd100, 8'd100,  4, 16'd10000, 1'b0,  6};
        vecs[1] = '{2, 8'd255, 8'd255,  4, 16'd65025, 1'b0,  6};
        vecs[2] = '{1, 8'd13,  8'd17,  15, 16'd221,   1'b0, 17};
        vecs[3] = '{0, 8'd9,   8'd9,    0, 16'd0,     1'b1, 17};
        vecs[4] = '{2, 8'd5,   8'd5,   16, 16'd0,     1'b1, 17};
        vecs[5] = '{1, 8'd200, 8'd3,   14, 16'd600,   1'b0, 16};
        vecs[6] = '{3, 8'd0,   8'd77,   2, 16'd0,     1'b0,  4};
        vecs[7] = '{3, 8'd128, 8'd2,    3, 16'd256,   1'b0,  5};

        // reset values, checked before any clock edge
        #2 reset_a = 1'b1;
        #1;
        chk("reset_ready", {28'd0, req_ready}, 32'd0);
        chk("reset_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        chk("reset_product", {16'd0, rsp_product}, 32'd0);
        chk("reset_error", {31'd0, rsp_error}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_start", {31'd0, mult_start}, 32'd0);
        chk("reset_dataa", {24'd0, mult_dataa}, 32'd0);
        chk("reset_datab", {24'd0, mult_datab}, 32'd0);
        chk("reset_state", {30'd0, dbg_state}, 32'd0);
        repeat (3) @(negedge clk);
        reset_a = 1'b0;

        // table of single operations (includes timeout and done-at-boundary)
        for (int v = 0; v < 8; v++)
            do_op(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].lat, 1'b0,
                  vecs[v].prod, vecs[v].err, vecs[v].rcyc);

        // four simultaneous requests, last grant was 3 -> order 0,1,2,3, back to back
        wait_idle();
        m_lat = 4; m_stale = 1'b0;
        op_a = '{8'd60, 8'd12, 8'd44, 8'd65};
        op_b = '{8'd200, 8'd90, 8'd190, 8'd111};
        exp_q.push_back({oh(0), 1'b0, 16'd12000});
        exp_q.push_back({oh(1), 1'b0, 16'd1080});
        exp_q.push_back({oh(2), 1'b0, 16'd8360});
        exp_q.push_back({oh(3), 1'b0, 16'd7215});
        run_burst(4'b1111, 4, 200, n_end, first_rdy);
        chk_order("rr4_order", 0, 1, 2, 3, 4);
        chk("rr4_total_cycles", n_end, 27);

        // 0 and 2 re-request: 0 before 2
        wait_idle();
        op_a[0] = 8'd7;  op_b[0] = 8'd8;
        op_a[2] = 8'd11; op_b[2] = 8'd12;
        exp_q.push_back({oh(0), 1'b0, 16'd56});
        exp_q.push_back({oh(2), 1'b0, 16'd132});
        run_burst(4'b0101, 2, 100, n_end, first_rdy);
        chk_order("rr2_order", 0, 2, 0, 0, 2);
        chk("rr2_total_cycles", n_end, 13);

        // stale done: high through LAUNCH and WAIT1, low, then high again 3 cycles later
        do_op(1, 8'd21, 8'd3, 0, 1'b1, 16'd63, 1'b0, 7);

        // timeout on requester 0, then pending requester 1 served normally
        wait_idle();
        m_lat = 0; m_stale = 1'b0;
        exp_q.push_back({oh(0), 1'b1, 16'd0});
        exp_q.push_back({oh(1), 1'b0, 16'd120});
        target = rsp_seen + 1;
        drive_req(0, 8'd50, 8'd50);
        n = 0; n1 = -1; n2 = -1;
        while (rsp_seen < target + 1 && n < 100) begin
            @(negedge clk);
            n++;
            if (req_ready[0]) req_valid[0] = 1'b0;
            if (req_ready[1]) req_valid[1] = 1'b0;
            if (n == 3) begin
                m_lat = 4;
                drive_req(1, 8'd30, 8'd4);
            end
            if (rsp_seen == target && n1 < 0) n1 = n;
            if (rsp_seen == target + 1 && n2 < 0) n2 = n;
        end
        chk("timeout_rsp_cycle", n1, 17);
        chk("pending_rsp_cycle", n2, 24);

        // reset during WAIT of 44x190: outputs clear at once, no response
        wait_idle();
        m_lat = 10;
        drive_req(2, 8'd44, 8'd190);
        @(negedge clk);
        req_valid[2] = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_state", {30'd0, dbg_state}, 32'd2);
        chk("pre_reset_dataa", {24'd0, mult_dataa}, 32'd44);
        reset_a = 1'b1;
        #1;
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_dataa", {24'd0, mult_dataa}, 32'd0);
        chk("midreset_datab", {24'd0, mult_datab}, 32'd0);
        chk("midreset_state", {30'd0, dbg_state}, 32'd0);
        chk("midreset_rsp", {28'd0, rsp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        reset_a = 1'b0;
        m_lat = 4;
        op_a[0] = 8'd3; op_b[0] = 8'd5;
        op_a[3] = 8'd6; op_b[3] = 8'd7;
        exp_q.push_back({oh(0), 1'b0, 16'd15});
        exp_q.push_back({oh(3), 1'b0, 16'd42});
        run_burst(4'b1001, 2, 100, n_end, first_rdy);
        chk_order("post_reset_order", 0, 3, 0, 0, 2);
        chk("post_reset_first_grant", first_rdy, 1);

        wait_idle();
        repeat (3) @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
